// File: rtl/uart_pkg.sv
// Shared UART definitions: receive state encoding, data width and default oversample ratio.
package uart_pkg;

    localparam int UART_DATA_BITS = 8;
    localparam int UART_OVERSAMPLE = 16;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_t;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for asynchronous inputs; RESET_VAL sets the value both flops reset to.
module uart_sync2 #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic sync_out
);

    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta     <= RESET_VAL;
            sync_out <= RESET_VAL;
        end else begin
            meta     <= async_in;
            sync_out <= meta;
        end
    end

endmodule

// File: rtl/uart_receiver.sv
// Oversampling UART receiver: start qualification, 8 data bits MSB first, stop check.
// Define UART_RX_PARITY_EN to add an even-parity bit before the stop bit and the parity_err port.
module uart_receiver
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = UART_OVERSAMPLE
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      rx_tick,
    input  logic                      rx_in,
    output logic [UART_DATA_BITS-1:0] RX_BYTE,
    output logic                      RX_VALID,
    output logic                      RX_BUSSY,
`ifdef UART_RX_PARITY_EN
    output logic                      parity_err,
`endif
    output logic                      frame_err
);

    localparam int CW = $clog2(OVERSAMPLE);
    localparam int IW = $clog2(UART_DATA_BITS);
    localparam logic [CW-1:0] HALF_LAST = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] FULL_LAST = CW'(OVERSAMPLE - 1);
    localparam logic [IW-1:0] MSB_IDX   = IW'(UART_DATA_BITS - 1);

    logic                      rx_s;
    rx_state_t                 state, state_nxt;
    logic [CW-1:0]             cnt, cnt_nxt;
    logic [IW-1:0]             bit_idx, bit_idx_nxt;
    logic [UART_DATA_BITS-1:0] shift, shift_nxt;
    logic                      brk, brk_nxt;
    logic                      valid_nxt, ferr_nxt;
`ifdef UART_RX_PARITY_EN
    logic                      par_bad, par_bad_nxt;
    logic                      perr_nxt;
`endif

    uart_sync2 #(.RESET_VAL(1'b1)) u_sync (
        .clk      (clk),
        .rst      (rst),
        .async_in (rx_in),
        .sync_out (rx_s)
    );

    assign RX_BUSSY = (state != IDLE);

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        bit_idx_nxt = bit_idx;
        shift_nxt   = shift;
        brk_nxt     = brk;
        valid_nxt   = 1'b0;
        ferr_nxt    = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_nxt = par_bad;
        perr_nxt    = 1'b0;
`endif
        if (rx_tick) begin
            cnt_nxt = (cnt == FULL_LAST) ? '0 : cnt + 1'b1;
            case (state)
                IDLE: begin
                    if (!rx_s) state_nxt = START;
                end
                START: begin
                    if (cnt == HALF_LAST) begin
                        state_nxt   = rx_s ? IDLE : DATA;
                        bit_idx_nxt = MSB_IDX;
                    end
                end
                DATA: begin
                    if (cnt == FULL_LAST) begin
                        shift_nxt = {shift[UART_DATA_BITS-2:0], rx_s};
                        if (bit_idx == '0) begin
`ifdef UART_RX_PARITY_EN
                            state_nxt = PARITY;
`else
                            state_nxt = STOP;
`endif
                        end else begin
                            bit_idx_nxt = bit_idx - 1'b1;
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (cnt == FULL_LAST) begin
                        par_bad_nxt = (rx_s != ^shift);
                        state_nxt   = STOP;
                    end
                end
`endif
                STOP: begin
                    // After a framing error, wait for the line to return high before re-arming.
                    if (brk) begin
                        if (rx_s) begin
                            brk_nxt   = 1'b0;
                            state_nxt = IDLE;
                        end
                    end else if (cnt == FULL_LAST) begin
                        if (rx_s) begin
                            valid_nxt = 1'b1;
`ifdef UART_RX_PARITY_EN
                            perr_nxt  = par_bad;
`endif
                            state_nxt = IDLE;
                        end else begin
                            ferr_nxt = 1'b1;
                            brk_nxt  = 1'b1;
                        end
                    end
                end
                default: state_nxt = IDLE;
            endcase
            if (state_nxt != state) cnt_nxt = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shift     <= '0;
            brk       <= 1'b0;
            RX_BYTE   <= '0;
            RX_VALID  <= 1'b0;
            frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad    <= 1'b0;
            parity_err <= 1'b0;
`endif
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            bit_idx   <= bit_idx_nxt;
            shift     <= shift_nxt;
            brk       <= brk_nxt;
            RX_VALID  <= valid_nxt;
            frame_err <= ferr_nxt;
            if (valid_nxt) RX_BYTE <= shift;
`ifdef UART_RX_PARITY_EN
            par_bad    <= par_bad_nxt;
            parity_err <= perr_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_uart_receiver.sv
// Directed plus randomized frames on a bit-level line model; expectations come from a frame-level model.
module tb_uart_receiver;

    localparam int OS = 16;
`ifdef UART_RX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    localparam int LAT = 2 + OS / 2 + (FRAME_BITS - 1) * OS;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx_tick;
    logic       rx_in;
    logic [7:0] RX_BYTE;
    logic       RX_VALID;
    logic       RX_BUSSY;
    logic       frame_err;
`ifdef UART_RX_PARITY_EN
    logic       parity_err;
`endif

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int valid_cnt = 0;
    int ferr_cnt = 0;
    int busy_cnt = 0;
    int perr_cnt = 0;
    int perr_with_valid = 0;
    int last_valid_cyc = 0;
    int valid_cyc_q[$];
    logic [7:0] valid_byte_q[$];

    logic [7:0] exp_byte = 8'h00;
    int exp_valids = 0;
    int exp_ferrs = 0;
    int exp_perrs = 0;
    int start_edge = 0;

    uart_receiver #(.OVERSAMPLE(OS)) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_tick    (rx_tick),
        .rx_in      (rx_in),
        .RX_BYTE    (RX_BYTE),
        .RX_VALID   (RX_VALID),
        .RX_BUSSY   (RX_BUSSY),
`ifdef UART_RX_PARITY_EN
        .parity_err (parity_err),
`endif
        .frame_err  (frame_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (RX_VALID) begin
            valid_cnt++;
            last_valid_cyc = cyc;
            valid_cyc_q.push_back(cyc);
            valid_byte_q.push_back(RX_BYTE);
        end
        if (frame_err) ferr_cnt++;
        if (RX_BUSSY) busy_cnt++;
`ifdef UART_RX_PARITY_EN
        if (parity_err) perr_cnt++;
        if (parity_err && RX_VALID) perr_with_valid++;
`endif
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic driveBit(input logic b, input int n);
        rx_in = b;
        repeat (n) @(negedge clk);
    endtask

    // One frame on the line; the model records what a correct receiver must report for it.
    task automatic applyStimulus(input logic [7:0] data, input logic par, input logic stop_val, input int stop_bits);
        if (stop_val) begin
            exp_valids++;
            exp_byte = data;
`ifdef UART_RX_PARITY_EN
            if (par != ^data) exp_perrs++;
`endif
        end else begin
            exp_ferrs++;
        end
        start_edge = cyc + 1;
        driveBit(1'b0, OS);
        for (int i = 7; i >= 0; i--) driveBit(data[i], OS);
`ifdef UART_RX_PARITY_EN
        driveBit(par, OS);
`else
        if (par === 1'bx) exp_byte = 8'hxx;
`endif
        driveBit(stop_val, stop_bits * OS);
        rx_in = 1'b1;
    endtask

    task automatic checkFrame(input string tag);
        checkOutput({tag, "_byte"}, 32'(RX_BYTE), 32'(exp_byte));
        checkOutput({tag, "_valids"}, valid_cnt, exp_valids);
        checkOutput({tag, "_ferrs"}, ferr_cnt, exp_ferrs);
`ifdef UART_RX_PARITY_EN
        checkOutput({tag, "_perrs"}, perr_cnt, exp_perrs);
        checkOutput({tag, "_perr_with_valid"}, perr_with_valid, exp_perrs);
`endif
    endtask

    initial begin
        logic [7:0] data;
        logic       good;
        logic       par;
        int         busy0;
        int         diff;

        rst = 1'b1;
        rx_in = 1'b1;
        rx_tick = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("reset_byte", 32'(RX_BYTE), 32'h00);
        checkOutput("reset_valid", 32'(RX_VALID), 32'h0);
        checkOutput("reset_frame_err", 32'(frame_err), 32'h0);
        checkOutput("reset_busy", 32'(RX_BUSSY), 32'h0);
        repeat (8) @(negedge clk);

        applyStimulus(8'hA5, ^8'hA5, 1'b1, 1);
        checkOutput("lat_a5", last_valid_cyc - start_edge, LAT);
        checkFrame("a5");
        repeat (20) @(negedge clk);

        busy0 = busy_cnt;
        driveBit(1'b0, 4);
        driveBit(1'b1, 30);
        checkOutput("glitch_busy_cycles", busy_cnt - busy0, 8);
        checkOutput("glitch_idle", 32'(RX_BUSSY), 32'h0);
        checkFrame("glitch");

        busy0 = busy_cnt;
        rx_tick = 1'b0;
        driveBit(1'b0, 12);
        checkOutput("stall_no_detect", busy_cnt - busy0, 0);
        driveBit(1'b1, 4);
        rx_tick = 1'b1;
        repeat (4) @(negedge clk);

        applyStimulus(8'h3C, ^8'h3C, 1'b0, 2);
        repeat (20) @(negedge clk);
        checkFrame("badstop_3c");
        applyStimulus(8'h81, ^8'h81, 1'b1, 1);
        checkFrame("after_break_81");
        repeat (10) @(negedge clk);

        valid_cyc_q.delete();
        valid_byte_q.delete();
        applyStimulus(8'h00, 1'b0, 1'b1, 1);
        applyStimulus(8'hFF, 1'b0, 1'b1, 1);
        checkOutput("b2b_count", valid_cyc_q.size(), 2);
        diff = (valid_cyc_q.size() >= 2) ? valid_cyc_q[1] - valid_cyc_q[0] : -1;
        checkOutput("b2b_spacing", diff, FRAME_BITS * OS);
        if (valid_byte_q.size() >= 2) begin
            checkOutput("b2b_first", 32'(valid_byte_q[0]), 32'h00);
            checkOutput("b2b_second", 32'(valid_byte_q[1]), 32'hFF);
        end
        checkFrame("b2b");
        repeat (10) @(negedge clk);

        data = 8'h5A;
        driveBit(1'b0, OS);
        for (int i = 7; i >= 5; i--) driveBit(data[i], OS);
        driveBit(data[4], OS / 2);
        rst = 1'b1;
        rx_in = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_byte = 8'h00;
        checkOutput("midreset_idle", 32'(RX_BUSSY), 32'h0);
        checkOutput("midreset_byte", 32'(RX_BYTE), 32'h00);
        repeat (3 * OS) @(negedge clk);
        checkFrame("midreset_5a");
        applyStimulus(8'h12, ^8'h12, 1'b1, 1);
        checkFrame("after_reset_12");
        repeat (10) @(negedge clk);

`ifdef UART_RX_PARITY_EN
        applyStimulus(8'h07, 1'b0, 1'b1, 1);
        checkFrame("par07_bad");
        repeat (10) @(negedge clk);
        applyStimulus(8'h07, 1'b1, 1'b1, 1);
        checkFrame("par07_good");
        repeat (10) @(negedge clk);
`endif

        for (int n = 0; n < 8; n++) begin
            data = 8'($urandom);
            good = ($urandom_range(0, 3) != 0);
            par = (^data) ^ 1'($urandom_range(0, 1));
            applyStimulus(data, par, good, good ? 1 : int'($urandom_range(1, 2)));
            repeat (good ? int'($urandom_range(0, 20)) : OS + int'($urandom_range(0, 20))) @(negedge clk);
            checkFrame("random");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
